ps2_scan_capture: RTL and testbench

PS/2 keyboard receiver feeding the four-digit seven-segment display path. It samples the keyboard's PS/2 clock and data lines and deserializes 11-bit frames. It checks start, parity and stop bits, and publishes each accepted scan code as a one-cycle strobe. It also keeps a 16-bit history word, `{previous code, newest code}`, which drives the LED driver's `dataIn` directly, so the display shows the last two scan codes in hex.

---
 rtl/ps2_scan_capture.sv | 148 ++++++++++++++
 tb/tb_ps2_scan_capture.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_capture.sv
// rtl/ps2_scan_capture.sv - PS/2 keyboard receiver with glitch filter, frame checking and two-byte display history
// Receive only: samples ps2Clk/ps2Data, never drives them.
module ps2_scan_capture #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 12500
) (
    input  logic        gclock,
    input  logic        greset,
    input  logic        ps2Clk,
    input  logic        ps2Data,
    output logic [7:0]  scanCode,
    output logic        codeValid,
    output logic [15:0] dataOut,
    output logic        frameError
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [7:0]    filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    scan_q, scan_d;
    logic          valid_q, valid_d;
    logic [15:0]   hist_q, hist_d;
    logic          err_q, err_d;
    logic          sample;
    logic          bit_in;

    // Filtered clock flips only after FILTER_LEN consecutive samples disagreeing with it.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2Clk};
        dat_sync_d = {dat_sync_q[0], ps2Data};
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end
        sample = filt_q & ~filt_d;
        bit_in = dat_sync_q[1];
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        to_cnt_d  = to_cnt_q;
        scan_d    = scan_q;
        valid_d   = 1'b0;
        hist_d    = hist_q;
        err_d     = err_q;
        if (state_q == S_IDLE) begin
            to_cnt_d = '0;
            if (sample && !bit_in) begin
                bit_cnt_d = '0;
                state_d   = S_DATA;
            end
        end else if (sample) begin
            // A sample event wins over a coincident timeout.
            to_cnt_d = '0;
            case (state_q)
                S_DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = bit_in;
                    state_d  = S_STOP;
                end
                default: begin
                    if (bit_in && ((^shift_q) ^ parity_q)) begin
                        scan_d  = shift_q;
                        hist_d  = {hist_q[7:0], shift_q};
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            endcase
        end else if (to_cnt_q == TW'(TIMEOUT)) begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge gclock or posedge greset) begin
        if (greset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            to_cnt_q   <= '0;
            scan_q     <= '0;
            valid_q    <= 1'b0;
            hist_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            to_cnt_q   <= to_cnt_d;
            scan_q     <= scan_d;
            valid_q    <= valid_d;
            hist_q     <= hist_d;
            err_q      <= err_d;
        end
    end

    assign scanCode   = scan_q;
    assign codeValid  = valid_q;
    assign dataOut    = hist_q;
    assign frameError = err_q;

endmodule

// File: tb/tb_ps2_scan_capture.sv
// tb/tb_ps2_scan_capture.sv - directed self-checking bench for ps2_scan_capture
module tb_ps2_scan_capture;

    localparam int FL = 8;
    localparam int TO = 300;

    logic        gclock = 1'b0;
    logic        greset;
    logic        ps2Clk;
    logic        ps2Data;
    logic [7:0]  scanCode;
    logic        codeValid;
    logic [15:0] dataOut;
    logic        frameError;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int dbl_cnt   = 0;
    logic prev_valid = 1'b0;

    ps2_scan_capture #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .gclock     (gclock),
        .greset     (greset),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .scanCode   (scanCode),
        .codeValid  (codeValid),
        .dataOut    (dataOut),
        .frameError (frameError)
    );

    always #5 gclock = ~gclock;

    always @(posedge gclock) begin
        prev_valid <= codeValid;
        if (codeValid) valid_cnt <= valid_cnt + 1;
        if (codeValid && prev_valid) dbl_cnt <= dbl_cnt + 1;
    end

    task automatic ps2_bit(input logic b, input int hi, input int lo, input bit glitch);
        ps2Data = b;
        if (glitch) begin
            repeat (6) @(negedge gclock);
            ps2Clk = 1'b0;
            repeat (FL - 1) @(negedge gclock);
            ps2Clk = 1'b1;
        end
        repeat (hi) @(negedge gclock);
        ps2Clk = 1'b0;
        if (glitch) begin
            repeat (6) @(negedge gclock);
            ps2Clk = 1'b1;
            repeat (FL - 1) @(negedge gclock);
            ps2Clk = 1'b0;
        end
        repeat (lo) @(negedge gclock);
        ps2Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                              input int hi, input int lo, input bit glitch);
        ps2_bit(1'b0, hi, lo, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], hi, lo, glitch);
        ps2_bit((~^d) ^ bad_par, hi, lo, glitch);
        ps2_bit(stop, hi, lo, glitch);
        ps2Data = 1'b1;
        repeat (30) @(negedge gclock);
    endtask

    task automatic test_reset;
        n_checks++; if (scanCode !== 8'h00) begin n_fail++; $display("FAIL reset_scan got %h want 00", scanCode); end
        n_checks++; if (dataOut !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", dataOut); end
        greset = 1'b0;
        repeat (20) @(negedge gclock);
        n_checks++; if ({codeValid, frameError} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {codeValid, frameError}); end
    endtask

    task automatic test_basic;
        int v0 = valid_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 20, 20, 1'b0);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL basic_valid got %0d want 1", valid_cnt - v0); end
        n_checks++; if (scanCode !== 8'h1C) begin n_fail++; $display("FAIL basic_scan got %h want 1c", scanCode); end
        n_checks++; if (dataOut !== 16'h001C) begin n_fail++; $display("FAIL basic_data got %h want 001c", dataOut); end
        n_checks++; if (frameError !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", frameError); end
    endtask

    task automatic test_history;
        int v0 = valid_cnt;
        send_frame(8'hF0, 1'b0, 1'b1, 20, 20, 1'b0);
        n_checks++; if (dataOut !== 16'h1CF0) begin n_fail++; $display("FAIL hist1_data got %h want 1cf0", dataOut); end
        send_frame(8'h1C, 1'b0, 1'b1, 20, 20, 1'b0);
        n_checks++; if (dataOut !== 16'hF01C) begin n_fail++; $display("FAIL hist2_data got %h want f01c", dataOut); end
        n_checks++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL hist_valid got %0d want 2", valid_cnt - v0); end
    endtask

    task automatic test_parity;
        int v0 = valid_cnt;
        send_frame(8'h32, 1'b1, 1'b1, 20, 20, 1'b0);
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL par_valid got %0d want 0", valid_cnt - v0); end
        n_checks++; if (frameError !== 1'b1) begin n_fail++; $display("FAIL par_err got %b want 1", frameError); end
        n_checks++; if (dataOut !== 16'hF01C) begin n_fail++; $display("FAIL par_data got %h want f01c", dataOut); end
        send_frame(8'h45, 1'b0, 1'b1, 20, 20, 1'b0);
        n_checks++; if (frameError !== 1'b0) begin n_fail++; $display("FAIL par_clr got %b want 0", frameError); end
        n_checks++; if (dataOut !== 16'h1C45) begin n_fail++; $display("FAIL par_good got %h want 1c45", dataOut); end
    endtask

    task automatic test_stop_timeout;
        int v0 = valid_cnt;
        send_frame(8'h29, 1'b0, 1'b0, 20, 20, 1'b0);
        n_checks++; if (frameError !== 1'b1) begin n_fail++; $display("FAIL stop_err got %b want 1", frameError); end
        n_checks++; if ({scanCode, dataOut} !== {8'h45, 16'h1C45}) begin n_fail++; $display("FAIL stop_hold got %h want 451c45", {scanCode, dataOut}); end
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL stop_valid got %0d want 0", valid_cnt - v0); end
        send_frame(8'h1C, 1'b0, 1'b1, 20, 20, 1'b0);
        n_checks++; if ({frameError, dataOut} !== {1'b0, 16'h451C}) begin n_fail++; $display("FAIL stop_recover got %h want 0451c", {frameError, dataOut}); end
        ps2_bit(1'b0, 20, 20, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 20, 20, 1'b0);
        ps2Data = 1'b1;
        repeat (TO / 2) @(negedge gclock);
        n_checks++; if (frameError !== 1'b0) begin n_fail++; $display("FAIL to_early got %b want 0", frameError); end
        repeat (TO / 2 + 10) @(negedge gclock);
        n_checks++; if (frameError !== 1'b1) begin n_fail++; $display("FAIL to_err got %b want 1", frameError); end
        send_frame(8'h1C, 1'b0, 1'b1, 20, 20, 1'b0);
        n_checks++; if ({frameError, scanCode, dataOut} !== {1'b0, 8'h1C, 16'h1C1C}) begin n_fail++; $display("FAIL to_after got %h want 01c1c1c", {frameError, scanCode, dataOut}); end
    endtask

    task automatic test_glitch;
        int v0 = valid_cnt;
        ps2Data = 1'b0;
        repeat (10) @(negedge gclock);
        ps2Clk = 1'b0;
        repeat (FL - 1) @(negedge gclock);
        ps2Clk = 1'b1;
        repeat (20) @(negedge gclock);
        send_frame(8'h5A, 1'b0, 1'b1, 20, 20, 1'b1);
        n_checks++; if ({frameError, dataOut} !== {1'b0, 16'h1C5A}) begin n_fail++; $display("FAIL glitch_data got %h want 01c5a", {frameError, dataOut}); end
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL glitch_valid got %0d want 1", valid_cnt - v0); end
        send_frame(8'h3B, 1'b0, 1'b1, 20, 10, 1'b0);
        n_checks++; if ({frameError, dataOut} !== {1'b0, 16'h5A3B}) begin n_fail++; $display("FAIL pulse10_data got %h want 05a3b", {frameError, dataOut}); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d = 8'hAA;
        ps2_bit(1'b0, 20, 20, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(d[i], 20, 20, 1'b0);
        ps2Data = d[4];
        repeat (20) @(negedge gclock);
        ps2Clk = 1'b0;
        repeat (3) @(negedge gclock);
        #2;
        greset  = 1'b1;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        #1;
        n_checks++; if ({scanCode, dataOut, codeValid, frameError} !== 26'h0) begin n_fail++; $display("FAIL async_reset got %h want 0", {scanCode, dataOut, codeValid, frameError}); end
        @(negedge gclock);
        greset = 1'b0;
        repeat (20) @(negedge gclock);
        send_frame(8'hAA, 1'b0, 1'b1, 20, 20, 1'b0);
        n_checks++; if ({frameError, scanCode, dataOut} !== {1'b0, 8'hAA, 16'h00AA}) begin n_fail++; $display("FAIL post_reset got %h want 0aa00aa", {frameError, scanCode, dataOut}); end
    endtask

    initial begin
        greset  = 1'b1;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        repeat (3) @(negedge gclock);
        test_reset;
        test_basic;
        test_history;
        test_parity;
        test_stop_timeout;
        test_glitch;
        test_reset_mid;
        n_checks++; if (dbl_cnt !== 0) begin n_fail++; $display("FAIL valid_width got %0d double pulses want 0", dbl_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
